jpeg_dec_dequant: RTL and testbench

//  Dequantizer for the JPEG decoder. Stores three 64-entry quantization tables (DQT) loaded per component ID.

---
 rtl/jpeg_dec_dequant.sv | 165 ++++++++++++++++
 tb/tb_jpeg_dec_dequant.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/jpeg_dec_dequant.sv
// JPEG decoder dequantizer: three DQT tables, coefficient x entry multiply,
// saturation to the coefficient width, DC/ID side-band carried with the data.
module jpeg_dec_dequant #(
    parameter int CW    = 12,
    parameter int QW    = 8,
    parameter int NCOMP = 3
) (
    input  logic          iCLK,
    input  logic          iRSTN,
    input  logic          iINIT,
    input  logic          iDEQT_EN,
    input  logic [QW-1:0] iDEQT_DAT,
    input  logic [1:0]    iDEQT_ID,
    input  logic          iPI_EN,
    input  logic [CW-1:0] iPI,
    input  logic          iPI_DC,
    input  logic [1:0]    iPI_ID,
    output logic          oPO_EN,
    output logic [CW-1:0] oPO,
    output logic          oPO_DC,
    output logic [1:0]    oPO_ID,
    output logic          oTBL_RDY,
    output logic          oERR
);
    localparam int DEPTH = NCOMP * 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int PW    = CW + QW + 1;
    localparam logic [1:0]    IDL  = 2'(NCOMP - 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LAST = LW'(DEPTH - 1);
    localparam logic signed [PW-1:0] PMAX =
        {{(QW + 2){1'b0}}, {(CW - 1){1'b1}}};
    localparam logic signed [PW-1:0] PMIN =
        {{(QW + 2){1'b1}}, {(CW - 1){1'b0}}};

    logic [QW-1:0] tbl [DEPTH];
    logic [5:0]    wr_idx;
    logic [5:0]    idx;
    logic [5:0]    k_cur;
    logic [LW-1:0] ld_cnt;
    logic          started;
    logic [1:0]    cur_id;
    logic          wr_ok;
    logic          wid_ok;
    logic          id_ok;
    logic          pi_err;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;

    logic          s1_v;
    logic [CW-1:0] s1_coef;
    logic          s1_dc;
    logic [1:0]    s1_id;
    logic          s1_bad;
    logic [QW-1:0] s1_q;
    logic signed [PW-1:0] prod;
    logic [CW-1:0] sat;

    assign k_cur  = iPI_DC ? 6'd0 : idx + 6'd1;
    assign wid_ok = (iDEQT_ID <= IDL);
    assign id_ok  = (iPI_ID <= IDL);
    assign wr_ok  = iDEQT_EN & wid_ok & ~iINIT;
    assign raddr  = id_ok ? AW'({iPI_ID, k_cur}) : '0;
    assign waddr  = AW'({iDEQT_ID, wr_idx});

    assign pi_err = iPI_EN & (
        (iPI_DC & started & (idx != 6'd63)) |
        (~iPI_DC & (~started | (idx == 6'd63))) |
        ~oTBL_RDY | ~id_ok |
        (~iPI_DC & started & (iPI_ID != cur_id)));

    // Table RAM: write strobe plus synchronous read; NBA gives read-before-write
    always_ff @(posedge iCLK) begin
        if (wr_ok)
            tbl[waddr] <= iDEQT_DAT;
        s1_q <= tbl[raddr];
    end

    // Control state: load/index counters, table-ready and sticky error flags
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            wr_idx   <= '0;
            ld_cnt   <= '0;
            oTBL_RDY <= 1'b0;
            idx      <= '0;
            started  <= 1'b0;
            cur_id   <= '0;
            oERR     <= 1'b0;
        end else if (iINIT) begin
            wr_idx   <= '0;
            ld_cnt   <= '0;
            oTBL_RDY <= 1'b0;
            idx      <= '0;
            started  <= 1'b0;
            cur_id   <= '0;
            oERR     <= 1'b0;
        end else begin
            if (iDEQT_EN)
                wr_idx <= wr_idx + 6'd1;
            if (wr_ok && ld_cnt != FULL)
                ld_cnt <= ld_cnt + 1'b1;
            if (wr_ok && ld_cnt == LAST)
                oTBL_RDY <= 1'b1;
            if (iPI_EN) begin
                idx     <= k_cur;
                started <= 1'b1;
                cur_id  <= iPI_ID;
            end
            if (pi_err || (iDEQT_EN && !wid_ok))
                oERR <= 1'b1;
        end
    end

    assign prod = $signed({{(QW + 1){s1_coef[CW-1]}}, s1_coef}) *
                  $signed({{(CW + 1){1'b0}}, s1_q});

    // Clamp the full-width product into the signed coefficient range
    always_comb begin
        sat = prod[CW-1:0];
        if (prod > PMAX)
            sat = {1'b0, {(CW - 1){1'b1}}};
        else if (prod < PMIN)
            sat = {1'b1, {(CW - 1){1'b0}}};
    end

    // Two-stage data pipeline: S1 captures the sample, S2 drives the outputs
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            s1_v    <= 1'b0;
            s1_coef <= '0;
            s1_dc   <= 1'b0;
            s1_id   <= '0;
            s1_bad  <= 1'b0;
            oPO_EN  <= 1'b0;
            oPO     <= '0;
            oPO_DC  <= 1'b0;
            oPO_ID  <= '0;
        end else if (iINIT) begin
            s1_v    <= 1'b0;
            s1_coef <= '0;
            s1_dc   <= 1'b0;
            s1_id   <= '0;
            s1_bad  <= 1'b0;
            oPO_EN  <= 1'b0;
            oPO     <= '0;
            oPO_DC  <= 1'b0;
            oPO_ID  <= '0;
        end else begin
            s1_v <= iPI_EN;
            if (iPI_EN) begin
                s1_coef <= iPI;
                s1_dc   <= iPI_DC;
                s1_id   <= iPI_ID;
                s1_bad  <= ~id_ok;
            end
            oPO_EN <= s1_v;
            if (s1_v) begin
                oPO    <= s1_bad ? '0 : sat;
                oPO_DC <= s1_dc;
                oPO_ID <= s1_id;
            end
        end
    end
endmodule

// File: tb/tb_jpeg_dec_dequant.sv
// Directed bench for jpeg_dec_dequant: table load, dequantization,
// saturation, multi-block streaming, collision and error/restart handling.
module tb_jpeg_dec_dequant;
    logic        iCLK = 1'b0;
    logic        iRSTN;
    logic        iINIT;
    logic        iDEQT_EN;
    logic [7:0]  iDEQT_DAT;
    logic [1:0]  iDEQT_ID;
    logic        iPI_EN;
    logic [11:0] iPI;
    logic        iPI_DC;
    logic [1:0]  iPI_ID;
    logic        oPO_EN;
    logic [11:0] oPO;
    logic        oPO_DC;
    logic [1:0]  oPO_ID;
    logic        oTBL_RDY;
    logic        oERR;

    int ntests = 0;
    int nfail  = 0;

    logic        e_v0 = 0, e_v1 = 0;
    logic [11:0] e_d0 = 0, e_d1 = 0;
    logic        e_c0 = 0, e_c1 = 0;
    logic [1:0]  e_i0 = 0, e_i1 = 0;

    jpeg_dec_dequant dut (
        .iCLK(iCLK), .iRSTN(iRSTN), .iINIT(iINIT),
        .iDEQT_EN(iDEQT_EN), .iDEQT_DAT(iDEQT_DAT), .iDEQT_ID(iDEQT_ID),
        .iPI_EN(iPI_EN), .iPI(iPI), .iPI_DC(iPI_DC), .iPI_ID(iPI_ID),
        .oPO_EN(oPO_EN), .oPO(oPO), .oPO_DC(oPO_DC), .oPO_ID(oPO_ID),
        .oTBL_RDY(oTBL_RDY), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [11:0] obs,
                        input logic [11:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: check output due now, then drive the next input
    task automatic step(input logic en, input logic [11:0] c,
                        input logic dc, input logic [1:0] id,
                        input logic [11:0] ev, input logic init = 1'b0);
        @(negedge iCLK);
        chk1("po_en", oPO_EN, e_v1);
        if (e_v1) begin
            chkw("po", oPO, e_d1);
            chk1("po_dc", oPO_DC, e_c1);
            chkw("po_id", {10'd0, oPO_ID}, {10'd0, e_i1});
        end
        e_v1 = e_v0; e_d1 = e_d0; e_c1 = e_c0; e_i1 = e_i0;
        e_v0 = en;   e_d0 = ev;   e_c0 = dc;   e_i0 = id;
        if (init) begin
            e_v0 = 1'b0;
            e_v1 = 1'b0;
        end
        iINIT    = init;
        iDEQT_EN = 1'b0;
        iPI_EN   = en;
        iPI      = c;
        iPI_DC   = dc;
        iPI_ID   = id;
    endtask

    task automatic idle();
        step(1'b0, 12'd0, 1'b0, 2'd0, 12'd0);
    endtask

    function automatic logic [11:0] exp4(input int id, input int k);
        int q;
        q = (id == 0) ? 1 : (id == 1) ? 2 : k + 1;
        return 12'((k - 32) * q);
    endfunction

    initial begin
        iRSTN = 0; iINIT = 0; iDEQT_EN = 0; iDEQT_DAT = 0; iDEQT_ID = 0;
        iPI_EN = 0; iPI = 0; iPI_DC = 0; iPI_ID = 0;
        repeat (3) @(negedge iCLK);
        chk1("rst_po_en", oPO_EN, 1'b0);
        chkw("rst_po", oPO, 12'd0);
        chk1("rst_rdy", oTBL_RDY, 1'b0);
        chk1("rst_err", oERR, 1'b0);
        chk1("rst_dc", oPO_DC, 1'b0);
        iRSTN = 1;

        // T1: table load
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 64; k++) begin
                @(negedge iCLK);
                if (t == 2 && k == 63)
                    chk1("rdy_before_last", oTBL_RDY, 1'b0);
                iDEQT_EN  = 1'b1;
                iDEQT_ID  = 2'(t);
                iDEQT_DAT = (t == 0) ? 8'd1 : (t == 1) ? 8'd2 : 8'(k + 1);
            end
        end
        @(negedge iCLK);
        iDEQT_EN = 1'b0;
        chk1("rdy_after_last", oTBL_RDY, 1'b1);
        chk1("err_after_load", oERR, 1'b0);

        // T2: ID2 block, coef 3
        for (int k = 0; k < 64; k++)
            step(1'b1, 12'd3, k == 0, 2'd2, 12'(3 * (k + 1)));
        idle(); idle(); idle();
        chkw("po_hold", oPO, 12'd192);
        chk1("err_t2", oERR, 1'b0);

        // T3: saturation on ID1 (q=2)
        step(1'b1, 12'h7FF, 1'b1, 2'd1, 12'h7FF);
        step(1'b1, 12'h801, 1'b0, 2'd1, 12'h800);
        step(1'b1, 12'h400, 1'b0, 2'd1, 12'h7FF);
        step(1'b1, 12'hFFB, 1'b0, 2'd1, 12'hFF6);
        step(1'b1, 12'h3FF, 1'b0, 2'd1, 12'h7FE);
        step(1'b1, 12'hC00, 1'b0, 2'd1, 12'h800);
        for (int k = 6; k < 64; k++)
            step(1'b1, 12'd0, 1'b0, 2'd1, 12'd0);
        idle(); idle();
        chk1("err_t3", oERR, 1'b0);

        // T4: blocks 0,1,2,0 with random gaps
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 64; k++) begin
                repeat ($urandom_range(0, 2)) idle();
                step(1'b1, 12'(k - 32), k == 0, 2'((b == 3) ? 0 : b),
                     exp4((b == 3) ? 0 : b, k));
            end
        end
        idle(); idle();
        chk1("err_t4", oERR, 1'b0);

        // T6: collision, write T1[5]=9 while reading T1 k=5
        for (int k = 0; k < 5; k++) begin
            idle();
            iDEQT_EN = 1'b1; iDEQT_ID = 2'd1; iDEQT_DAT = 8'd2;
        end
        for (int k = 0; k < 64; k++) begin
            step(1'b1, 12'd1, k == 0, 2'd1, 12'd2);
            if (k == 5) begin
                iDEQT_EN = 1'b1; iDEQT_ID = 2'd1; iDEQT_DAT = 8'd9;
            end
        end
        for (int k = 0; k < 10; k++)
            step(1'b1, 12'd1, k == 0, 2'd1, (k == 5) ? 12'd9 : 12'd2);
        chk1("err_t6", oERR, 1'b0);

        // T5: DC mid-block at k=10, index restarts, then iINIT
        step(1'b1, 12'd1, 1'b1, 2'd1, 12'd2);
        for (int k = 1; k < 6; k++) begin
            step(1'b1, 12'd1, 1'b0, 2'd1, (k == 5) ? 12'd9 : 12'd2);
            if (k == 1)
                chk1("err_dc_mid", oERR, 1'b1);
        end
        step(1'b0, 12'd0, 1'b0, 2'd0, 12'd0, 1'b1);
        idle();
        chk1("err_after_init", oERR, 1'b0);
        chk1("rdy_after_init", oTBL_RDY, 1'b0);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
